// File: rtl/preset_count_sequencer.sv
// preset_count_sequencer: a loadable up/down counter with a five-state run
// controller. A run loads a preset value, counts toward a terminal value and
// then either finishes (one-shot) or reloads and keeps going (auto-reload).
// All state changes happen on the falling edge of CLK. CLR is an asynchronous,
// active-high reset.
module preset_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic             MODE,
    input  logic             DIR,
    input  logic             HOLD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic [WIDTH-1:0] TERM_VAL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] T,
    output logic             BUSY,
    output logic             TC,
    output logic             DONE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] load_sh;
    logic [WIDTH-1:0] term_sh;
    logic             mode_sh;
    logic             dir_sh;
    logic [WIDTH-1:0] q_step;

    // Next count value in the captured direction; wraps modulo 2^WIDTH.
    assign q_step = dir_sh ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));

    // Status flags decoded straight from the state register.
    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_DONE);

    // Controller, counter, toggle mask and terminal pulse, all on the falling edge.
    // NOTE: every register here uses <= so all updates see the pre-edge values of
    // Q and the shadows; T is computed from the old Q in the same edge.
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            state   <= S_IDLE;
            Q       <= '0;
            T       <= '0;
            TC      <= 1'b0;
            load_sh <= '0;
            term_sh <= '0;
            mode_sh <= 1'b0;
            dir_sh  <= 1'b0;
        end else begin
            // Pulse-type outputs default to 0 on edges that do not drive them.
            T  <= '0;
            TC <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) state <= S_LOAD;
                end
                S_LOAD: begin
                    Q       <= LOAD_VAL;
                    T       <= LOAD_VAL ^ Q;
                    load_sh <= LOAD_VAL;
                    term_sh <= TERM_VAL;
                    mode_sh <= MODE;
                    dir_sh  <= DIR;
                    state   <= S_COUNT;
                end
                S_COUNT: begin
                    if (HOLD) begin
                        // Pause wins over terminal detection; Q and TC stay quiet.
                        state <= S_PAUSE;
                    end else if (Q == term_sh) begin
                        TC <= 1'b1;
                        if (mode_sh) begin
                            Q <= load_sh;
                            T <= load_sh ^ Q;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        Q <= q_step;
                        T <= q_step ^ Q;
                    end
                end
                S_PAUSE: begin
                    if (!HOLD) state <= S_COUNT;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_preset_count_sequencer.sv
// Self-checking bench for preset_count_sequencer (WIDTH=4). Each scenario task
// pushes per-edge stimulus and expected outputs to a scoreboard queue; the
// drain task applies the stimulus, clocks one falling edge and compares.
module tb_preset_count_sequencer;

    logic       CLK;
    logic       CLR;
    logic       START;
    logic       MODE;
    logic       DIR;
    logic       HOLD;
    logic [3:0] LOAD_VAL;
    logic [3:0] TERM_VAL;
    logic [3:0] Q;
    logic [3:0] T;
    logic       BUSY;
    logic       TC;
    logic       DONE;

    int checks = 0;
    int errors = 0;
    string cur_test = "none";

    typedef struct {
        logic       start;
        logic       hold;
        logic [3:0] q;
        logic [3:0] t;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model_q;

    preset_count_sequencer #(.WIDTH(4)) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .START   (START),
        .MODE    (MODE),
        .DIR     (DIR),
        .HOLD    (HOLD),
        .LOAD_VAL(LOAD_VAL),
        .TERM_VAL(TERM_VAL),
        .Q       (Q),
        .T       (T),
        .BUSY    (BUSY),
        .TC      (TC),
        .DONE    (DONE)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    // Queue one edge: inputs before the edge, outputs expected after it.
    // The expected toggle mask is new Q XOR previous expected Q (0 when Q holds).
    task automatic push(input logic start, input logic hold, input logic [3:0] q,
                        input logic tc, input logic busy, input logic done);
        exp_t e;
        e.start = start;
        e.hold  = hold;
        e.q     = q;
        e.t     = q ^ model_q;
        e.tc    = tc;
        e.busy  = busy;
        e.done  = done;
        model_q = q;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        int   n;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n++;
            @(posedge CLK);
            START = e.start;
            HOLD  = e.hold;
            @(negedge CLK);
            #1;
            checks++;
            if (Q !== e.q) begin
                errors++;
                $display("FAIL %s edge%0d Q got %0d expected %0d", cur_test, n, Q, e.q);
            end
            checks++;
            if (T !== e.t) begin
                errors++;
                $display("FAIL %s edge%0d T got %b expected %b", cur_test, n, T, e.t);
            end
            checks++;
            if (TC !== e.tc) begin
                errors++;
                $display("FAIL %s edge%0d TC got %b expected %b", cur_test, n, TC, e.tc);
            end
            checks++;
            if (BUSY !== e.busy) begin
                errors++;
                $display("FAIL %s edge%0d BUSY got %b expected %b", cur_test, n, BUSY, e.busy);
            end
            checks++;
            if (DONE !== e.done) begin
                errors++;
                $display("FAIL %s edge%0d DONE got %b expected %b", cur_test, n, DONE, e.done);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if ({Q, T, TC, BUSY, DONE} !== 11'b0) begin
            errors++;
            $display("FAIL %s Q/T/TC/BUSY/DONE got %0d/%b/%b/%b/%b expected all zero",
                     tag, Q, T, TC, BUSY, DONE);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        #2;
        check_cleared("reset_initial");
        // Falling edges while CLR is high do nothing, even with START asserted.
        START = 1'b1;
        @(negedge CLK);
        #1;
        check_cleared("reset_edge_ignored");
        @(posedge CLK);
        CLR   = 1'b0;
        START = 1'b0;
        model_q = 4'd0;
    endtask

    task automatic test_one_shot_up();
        cur_test = "one_shot_up";
        LOAD_VAL = 4'd3; TERM_VAL = 4'd6; DIR = 1'b1; MODE = 1'b0;
        push(1, 0, 4'd0, 0, 1, 0);   // IDLE -> LOAD
        push(0, 0, 4'd3, 0, 1, 0);   // LOAD
        push(0, 0, 4'd4, 0, 1, 0);
        push(0, 0, 4'd5, 0, 1, 0);
        push(0, 0, 4'd6, 0, 1, 0);
        push(0, 0, 4'd6, 1, 1, 1);   // terminal: TC and DONE
        push(0, 0, 4'd6, 0, 0, 0);   // back in IDLE
        push(0, 0, 4'd6, 0, 0, 0);
        drain();
    endtask

    task automatic test_hold_at_terminal();
        cur_test = "hold_terminal";
        push(1, 0, 4'd6, 0, 1, 0);
        push(0, 0, 4'd3, 0, 1, 0);
        push(0, 0, 4'd4, 0, 1, 0);
        push(0, 0, 4'd5, 0, 1, 0);
        push(0, 0, 4'd6, 0, 1, 0);
        push(0, 1, 4'd6, 0, 1, 0);   // HOLD beats terminal detection
        push(0, 1, 4'd6, 0, 1, 0);
        push(0, 1, 4'd6, 0, 1, 0);
        push(0, 0, 4'd6, 0, 1, 0);   // PAUSE -> COUNT
        push(0, 0, 4'd6, 1, 1, 1);
        push(0, 0, 4'd6, 0, 0, 0);
        drain();
    endtask

    task automatic test_equal_values();
        cur_test = "equal_values";
        LOAD_VAL = 4'd9; TERM_VAL = 4'd9; MODE = 1'b0; DIR = 1'b1;
        push(1, 0, 4'd6, 0, 1, 0);
        push(0, 0, 4'd9, 0, 1, 0);
        push(0, 0, 4'd9, 1, 1, 1);   // TC at first COUNT edge
        push(0, 0, 4'd9, 0, 0, 0);   // three busy periods total
        drain();
    endtask

    task automatic test_auto_reload_down();
        cur_test = "auto_reload_down";
        LOAD_VAL = 4'd1; TERM_VAL = 4'd14; DIR = 1'b0; MODE = 1'b1;
        push(1, 0, 4'd9, 0, 1, 0);
        push(1, 0, 4'd1, 0, 1, 0);   // START held: ignored outside IDLE
        push(1, 0, 4'd0, 0, 1, 0);
        push(1, 0, 4'd15, 0, 1, 0);  // wrap, no TC
        push(1, 0, 4'd14, 0, 1, 0);
        push(1, 0, 4'd1, 1, 1, 0);   // reload, no DONE
        push(1, 0, 4'd0, 0, 1, 0);
        push(1, 0, 4'd15, 0, 1, 0);
        push(1, 0, 4'd14, 0, 1, 0);
        push(1, 0, 4'd1, 1, 1, 0);
        push(1, 0, 4'd0, 0, 1, 0);
        drain();
        // Abort the endless run between edges.
        #2;
        CLR = 1'b1;
        #1;
        check_cleared("auto_reload_abort");
        @(posedge CLK);
        CLR   = 1'b0;
        START = 1'b0;
        model_q = 4'd0;
    endtask

    task automatic test_async_reset();
        cur_test = "async_reset";
        LOAD_VAL = 4'd3; TERM_VAL = 4'd12; DIR = 1'b1; MODE = 1'b0;
        push(1, 0, 4'd0, 0, 1, 0);
        push(1, 0, 4'd3, 0, 1, 0);
        push(1, 0, 4'd4, 0, 1, 0);
        push(1, 0, 4'd5, 0, 1, 0);
        drain();
        #2;
        CLR = 1'b1;
        #1;
        check_cleared("async_clear_immediate");
        @(negedge CLK);
        #1;
        check_cleared("async_clear_held");
        @(posedge CLK);
        CLR   = 1'b0;
        START = 1'b0;
        model_q = 4'd0;
        // No resumption without a new START.
        TERM_VAL = 4'd4;
        push(0, 0, 4'd0, 0, 0, 0);
        push(0, 0, 4'd0, 0, 0, 0);
        push(1, 0, 4'd0, 0, 1, 0);
        push(0, 0, 4'd3, 0, 1, 0);
        push(0, 0, 4'd4, 0, 1, 0);
        push(0, 0, 4'd4, 1, 1, 1);
        push(0, 0, 4'd4, 0, 0, 0);
        drain();
    endtask

    task automatic test_toggle_mask();
        cur_test = "toggle_mask";
        LOAD_VAL = 4'd7; TERM_VAL = 4'd9; DIR = 1'b1; MODE = 1'b0;
        push(1, 0, 4'd4, 0, 1, 0);
        push(0, 0, 4'd7, 0, 1, 0);
        drain();
        // Inputs changed outside LOAD must not disturb the run.
        LOAD_VAL = 4'd0; TERM_VAL = 4'd15; DIR = 1'b0; MODE = 1'b1;
        push(0, 0, 4'd8, 0, 1, 0);   // T = 1111
        push(0, 0, 4'd9, 0, 1, 0);   // T = 0001
        push(0, 0, 4'd9, 1, 1, 1);
        push(0, 0, 4'd9, 0, 0, 0);
        drain();
    endtask

    initial begin
        CLR = 1'b1; START = 1'b0; MODE = 1'b0; DIR = 1'b0; HOLD = 1'b0;
        LOAD_VAL = 4'd0; TERM_VAL = 4'd0;
        model_q = 4'd0;
        test_reset();
        test_one_shot_up();
        test_hold_at_terminal();
        test_equal_values();
        test_auto_reload_down();
        test_async_reset();
        test_toggle_mask();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
